pixel_frame_capture: RTL and testbench
======================================

# pixel_frame_capture

Output-side counterpart to the pixel feeder in front of `convolution`. It takes the convolution's pixel stream, which arrives in bottom-left to top-right raster order, and discards the pipeline warm-up pixels. It then writes each captured pixel into a frame-buffer write port at its row-major address. Frame-start and frame-done are signalled with a small FSM. A small {address, data} FIFO absorbs write-port stalls, because the convolution stream has no backpressure.

## Interface
Parameters:
- WORD_SIZE, 8, pixel width in bits
- IMAGE_WIDTH, 540, pixels per row
- IMAGE_HEIGHT, 360, rows per frame
- SKIP_COUNT, 0, valid pixels discarded after `start`, before capture begins
- FIFO_DEPTH, 4, write-buffer entries (power of 2, ≥2)
- ADDR_WIDTH, 18, frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT

Ports:
- clk  in  1  the block's single clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle frame start request, honoured only in IDLE
- pixelValid  in  1  `outputPixel` is valid this cycle
- outputPixel  in  WORD_SIZE  pixel from `convolution`
- memReady  in  1  frame buffer accepts the write this cycle
- memWe  out  1  write request
- memAddr  out  ADDR_WIDTH  write address, row*IMAGE_WIDTH+col
- memData  out  WORD_SIZE  write data
- busy  out  1  high in SKIP, CAPTURE and DRAIN
- frameDone  out  1  one-cycle pulse, emitted in DONE
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

## Operation
- FSM states: IDLE, SKIP, CAPTURE, DRAIN, DONE.
- IDLE with `start`:
  - Go to SKIP, or directly to CAPTURE if SKIP_COUNT=0.
  - Clear `overflow`, the skip counter and the pixel counter.
  - Set the write position to row IMAGE_HEIGHT-1, col 0.
- `start` outside IDLE is ignored.
- SKIP:
  - Each valid pixel increments the skip counter and is discarded.
  - When the SKIP_COUNT-th valid pixel arrives, go to CAPTURE. That pixel is not captured.
- CAPTURE:
  - Each valid pixel is "accepted": its current address and data are pushed into the FIFO.
  - The position then advances: col+1. When col=IMAGE_WIDTH-1, col wraps to 0 and row decrements.
  - The address register tracks this by adding 1, or by subtracting 2*IMAGE_WIDTH-1 on wrap. No multiplier is used.
- FIFO full with no pop that cycle:
  - The pixel is dropped and `overflow` is set.
  - The position still advances, so frame geometry is preserved.
- FIFO full with a pop in the same cycle: the push succeeds.
- After the IMAGE_WIDTH*IMAGE_HEIGHT-th valid pixel (row 0, col IMAGE_WIDTH-1, address IMAGE_WIDTH-1), go to DRAIN.
- DRAIN:
  - Valid pixels are ignored.
  - When the FIFO becomes empty, go to DONE.
- DONE: `frameDone`=1 for exactly one cycle, then IDLE.
- IDLE and DONE ignore `pixelValid`.
- Write port:
  - `memWe` = FIFO not empty; `memAddr`/`memData` come from the FIFO head.
  - A handshake is `memWe && memReady`, which pops the entry.
  - While `memWe` is high and `memReady` is low, `memAddr` and `memData` hold stable.
- Reset (async, any time, including mid-frame):
  - State goes to IDLE, the FIFO is emptied and all counters are zeroed.
  - All outputs go to 0: `memWe`, `memAddr`, `memData`, `busy`, `frameDone` and `overflow`.
  - No partial write completes after reset.

## Timing
- `start` sampled at edge k: state changes at k, so `busy`=1 from the cycle after k.
- Pixel accepted at edge k: `memWe` rises and the entry is presented in the cycle after k. With `memReady` held high, write latency is 1 cycle, giving sustained 1 pixel/cycle.
- A pixel every other cycle, as the feeder produces, never fills the FIFO while `memReady` stays high.
- Final write handshake at edge n:
  - DRAIN→DONE at edge n, or at n+1 if the final accept and final pop coincide.
  - `frameDone` is high for the following cycle; `busy` is low in that same cycle.
- `overflow` is set at the edge of the dropped push and holds until the next accepted `start` or reset.

## Test plan
Parameters for all scenarios unless stated: W=4, H=3, SKIP_COUNT=2, FIFO_DEPTH=4, `memReady`=1.
- Basic frame: `start`, then 14 valid pixels 0x00..0x0D, one every 2 cycles.
  - 0x00 and 0x01 are skipped.
  - Writes go to addresses 8,9,10,11,4,5,6,7,0,1,2,3 with data 0x02..0x0D.
  - One `frameDone` pulse; `overflow`=0.
- Backpressure: basic frame, continuous pixels, `memReady` low for 3 cycles mid-frame.
  - No loss; order is preserved.
  - `memAddr`/`memData` stay stable while stalled.
- Overflow: `memReady`=0 for the whole frame after `start`, continuous pixels.
  - The first 4 captured pixels are buffered (addresses 8..11) and the rest are dropped.
  - `overflow`=1. Raising `memReady` drains 4 writes, then `frameDone`.
- SKIP_COUNT=0 with `start` asserted while busy:
  - Capture begins at the first valid pixel; the second `start` has no effect.
  - Exactly 12 writes occur.
- Reset mid-frame: assert `rst`=0 after 5 captures with the FIFO holding 2 entries.
  - All outputs read 0 immediately and no further writes occur.
  - A fresh `start` then reproduces the basic-frame result exactly.
- Simultaneous push and pop with the FIFO full: no drop, `overflow` stays 0.

Source files
------------

// File: rtl/pixel_frame_capture.sv
// Captures a bottom-left-first raster pixel stream into a row-major frame buffer.
// A small {address, data} FIFO absorbs write-port stalls since the stream cannot be throttled.
module pixel_frame_capture #(
    parameter int WORD_SIZE    = 8,
    parameter int IMAGE_WIDTH  = 540,
    parameter int IMAGE_HEIGHT = 360,
    parameter int SKIP_COUNT   = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pixelValid,
    input  logic [WORD_SIZE-1:0]  outputPixel,
    input  logic                  memReady,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [WORD_SIZE-1:0]  memData,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  overflow
);
    localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int COL_W      = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int PIX_W      = $clog2(NUM_PIXELS + 1);
    localparam int SKIP_W     = (SKIP_COUNT > 0) ? $clog2(SKIP_COUNT + 1) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W    = ADDR_WIDTH + WORD_SIZE;

    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [PIX_W-1:0]      PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [SKIP_W-1:0]     SKIP_LAST  = SKIP_W'((SKIP_COUNT > 0) ? SKIP_COUNT - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'((IMAGE_HEIGHT - 1) * IMAGE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_WRAP  = ADDR_WIDTH'(2 * IMAGE_WIDTH - 1);
    localparam logic [PTR_W:0]        ONE_ENTRY  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {IDLE, SKIP, CAPTURE, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [SKIP_W-1:0]     skipCnt_q, skipCnt_d;
    logic [PIX_W-1:0]      pixCnt_q, pixCnt_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  overflow_q, overflow_d;

    logic [ENTRY_W-1:0]    fifoMem_q [FIFO_DEPTH];
    logic [PTR_W:0]        wrPtr_q, rdPtr_q;
    logic [PTR_W:0]        fifoCount;
    logic [ENTRY_W-1:0]    head;
    logic                  fifoEmpty, fifoFull, push, pop, startAccept, captureValid;

    assign startAccept  = (state_q == IDLE) && start;
    assign captureValid = (state_q == CAPTURE) && pixelValid;
    assign fifoEmpty    = (wrPtr_q == rdPtr_q);
    assign fifoFull     = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                          (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign fifoCount    = wrPtr_q - rdPtr_q;
    assign pop          = !fifoEmpty && memReady;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push         = captureValid && (!fifoFull || pop);
    assign head         = fifoMem_q[rdPtr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (SKIP_COUNT == 0) ? CAPTURE : SKIP;
            SKIP:    if (pixelValid && skipCnt_q == SKIP_LAST) state_d = CAPTURE;
            CAPTURE: if (pixelValid && pixCnt_q == PIX_LAST) state_d = DRAIN;
            DRAIN:   if (fifoEmpty || (fifoCount == ONE_ENTRY && pop)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == SKIP) || (state_q == CAPTURE) || (state_q == DRAIN);
        frameDone = (state_q == DONE);
        memWe     = !fifoEmpty;
        memAddr   = '0;
        memData   = '0;
        if (!fifoEmpty) begin
            memAddr = head[ENTRY_W-1:WORD_SIZE];
            memData = head[WORD_SIZE-1:0];
        end
    end

    assign overflow = overflow_q;

    // Rows are walked bottom-up, so a row wrap steps the address back by two rows minus one.
    always_comb begin
        skipCnt_d  = skipCnt_q;
        pixCnt_d   = pixCnt_q;
        col_d      = col_q;
        addr_d     = addr_q;
        overflow_d = overflow_q;
        if (startAccept) begin
            skipCnt_d  = '0;
            pixCnt_d   = '0;
            col_d      = '0;
            addr_d     = ADDR_FIRST;
            overflow_d = 1'b0;
        end else if (state_q == SKIP && pixelValid) begin
            skipCnt_d = skipCnt_q + 1'b1;
        end else if (captureValid) begin
            pixCnt_d = pixCnt_q + 1'b1;
            if (col_q == COL_LAST) begin
                col_d  = '0;
                addr_d = addr_q - ADDR_WRAP;
            end else begin
                col_d  = col_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
            if (!push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skipCnt_q  <= '0;
            pixCnt_q   <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
        end else begin
            skipCnt_q  <= skipCnt_d;
            pixCnt_q   <= pixCnt_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q[PTR_W-1:0]] <= {addr_q, outputPixel};
    end

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture on a 4x3 frame: one instance skipping
// two warm-up pixels, one skipping none.
module tb_pixel_frame_capture;
   logic       clk;
   logic       rst;

   logic       startA, validA, readyA;
   logic [7:0] pixA;
   logic       weA, busyA, doneA, ovfA;
   logic [3:0] addrA;
   logic [7:0] dataA;

   logic       startB, validB, readyB;
   logic [7:0] pixB;
   logic       weB, busyB, doneB, ovfB;
   logic [3:0] addrB;
   logic [7:0] dataB;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [3:0] logAddrA[$];
   logic [7:0] logDataA[$];
   int         doneCntA, lastHsA, doneCycA;
   logic       busyAtDoneA;
   logic [3:0] logAddrB[$];
   logic [7:0] logDataB[$];
   int         doneCntB;

   int expAddr[12] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};

   pixel_frame_capture #(
      .WORD_SIZE(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
      .SKIP_COUNT(2), .FIFO_DEPTH(4), .ADDR_WIDTH(4)
   ) dutA (
      .clk(clk), .rst(rst), .start(startA), .pixelValid(validA),
      .outputPixel(pixA), .memReady(readyA), .memWe(weA), .memAddr(addrA),
      .memData(dataA), .busy(busyA), .frameDone(doneA), .overflow(ovfA)
   );

   pixel_frame_capture #(
      .WORD_SIZE(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
      .SKIP_COUNT(0), .FIFO_DEPTH(4), .ADDR_WIDTH(4)
   ) dutB (
      .clk(clk), .rst(rst), .start(startB), .pixelValid(validB),
      .outputPixel(pixB), .memReady(readyB), .memWe(weB), .memAddr(addrB),
      .memData(dataB), .busy(busyB), .frameDone(doneB), .overflow(ovfB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write handshake and frameDone pulse seen at the active edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (weA && readyA) begin
         logAddrA.push_back(addrA);
         logDataA.push_back(dataA);
         lastHsA = cyc;
      end
      if (doneA) begin
         doneCntA = doneCntA + 1;
         doneCycA = cyc;
         busyAtDoneA = busyA;
      end
      if (weB && readyB) begin
         logAddrB.push_back(addrB);
         logDataB.push_back(dataB);
      end
      if (doneB) doneCntB = doneCntB + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearLogs();
      logAddrA.delete(); logDataA.delete();
      logAddrB.delete(); logDataB.delete();
      doneCntA = 0; doneCntB = 0; lastHsA = -100; doneCycA = -200; busyAtDoneA = 1'b1;
   endtask

   task automatic pulseStartA();
      startA = 1'b1;
      tick();
      startA = 1'b0;
   endtask

   task automatic waitDoneA(input int maxCyc);
      int n = 0;
      while (doneCntA == 0 && n < maxCyc) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (doneCntA != 1) begin
         errors++;
         $display("[TB] FAIL doneCountA: got %0d pulses, need 1", doneCntA);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if ({weA, addrA, dataA, busyA, doneA, ovfA} !== 16'h0) begin
         errors++;
         $display("[TB] FAIL resetOutputs: got %h, need 0", {weA, addrA, dataA, busyA, doneA, ovfA});
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (busyA !== 1'b0 || weA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idleAfterReset: busy=%b we=%b, need 0 0", busyA, weA);
      end
   endtask

   task automatic test_basic_frame();
      clearLogs();
      readyA = 1'b1;
      pulseStartA();
      checks++;
      if (busyA !== 1'b1 || ovfA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busyAfterStart: busy=%b ovf=%b, need 1 0", busyA, ovfA);
      end
      for (int i = 0; i < 14; i++) begin
         validA = 1'b1;
         pixA = 8'(i);
         tick();
         validA = 1'b0;
         if (i == 2) begin
            checks++;
            if (weA !== 1'b1 || addrA !== 4'd8 || dataA !== 8'h02) begin
               errors++;
               $display("[TB] FAIL firstWriteLatency: we=%b addr=%0d data=%h, need 1 8 02", weA, addrA, dataA);
            end
         end
         tick();
      end
      waitDoneA(20);
      checks++;
      if (logAddrA.size() != 12) begin
         errors++;
         $display("[TB] FAIL basicWriteCount: got %0d, need 12", logAddrA.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (logAddrA[i] !== 4'(expAddr[i]) || logDataA[i] !== 8'(i + 2)) begin
               errors++;
               $display("[TB] FAIL basicWrite%0d: addr=%0d data=%h, need %0d %h", i, logAddrA[i], logDataA[i], expAddr[i], 8'(i + 2));
            end
         end
      end
      checks++;
      if (doneCycA != lastHsA + 1 || busyAtDoneA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL doneTiming: done cycle %0d busy=%b, need %0d busy=0", doneCycA, busyAtDoneA, lastHsA + 1);
      end
      checks++;
      if (ovfA !== 1'b0 || busyA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basicEnd: ovf=%b busy=%b, need 0 0", ovfA, busyA);
      end
   endtask

   task automatic test_backpressure();
      clearLogs();
      readyA = 1'b1;
      pulseStartA();
      for (int i = 0; i < 14; i++) begin
         validA = 1'b1;
         pixA = 8'(i);
         readyA = (i >= 6 && i <= 8) ? 1'b0 : 1'b1;
         tick();
         if (i >= 6 && i <= 8) begin
            checks++;
            if (weA !== 1'b1 || addrA !== 4'd11 || dataA !== 8'h05) begin
               errors++;
               $display("[TB] FAIL stallStable%0d: we=%b addr=%0d data=%h, need 1 11 05", i, weA, addrA, dataA);
            end
         end
      end
      validA = 1'b0;
      readyA = 1'b1;
      waitDoneA(20);
      checks++;
      if (logAddrA.size() != 12) begin
         errors++;
         $display("[TB] FAIL bpWriteCount: got %0d, need 12", logAddrA.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (logAddrA[i] !== 4'(expAddr[i]) || logDataA[i] !== 8'(i + 2)) begin
               errors++;
               $display("[TB] FAIL bpWrite%0d: addr=%0d data=%h, need %0d %h", i, logAddrA[i], logDataA[i], expAddr[i], 8'(i + 2));
            end
         end
      end
      checks++;
      if (ovfA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fullPushPop: overflow=%b, need 0", ovfA);
      end
   endtask

   task automatic test_overflow();
      clearLogs();
      readyA = 1'b0;
      pulseStartA();
      for (int i = 0; i < 14; i++) begin
         validA = 1'b1;
         pixA = 8'(i);
         tick();
      end
      validA = 1'b0;
      checks++;
      if (ovfA !== 1'b1 || busyA !== 1'b1 || weA !== 1'b1 || addrA !== 4'd8 || dataA !== 8'h02) begin
         errors++;
         $display("[TB] FAIL overflowHeld: ovf=%b busy=%b we=%b addr=%0d data=%h, need 1 1 1 8 02", ovfA, busyA, weA, addrA, dataA);
      end
      checks++;
      if (doneCntA != 0 || logAddrA.size() != 0) begin
         errors++;
         $display("[TB] FAIL overflowStalled: done=%0d writes=%0d, need 0 0", doneCntA, logAddrA.size());
      end
      readyA = 1'b1;
      waitDoneA(20);
      checks++;
      if (logAddrA.size() != 4) begin
         errors++;
         $display("[TB] FAIL overflowWriteCount: got %0d, need 4", logAddrA.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (logAddrA[i] !== 4'(8 + i) || logDataA[i] !== 8'(i + 2)) begin
               errors++;
               $display("[TB] FAIL overflowWrite%0d: addr=%0d data=%h, need %0d %h", i, logAddrA[i], logDataA[i], 8 + i, 8'(i + 2));
            end
         end
      end
      checks++;
      if (ovfA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overflowSticky: got %b, need 1", ovfA);
      end
   endtask

   task automatic test_skip0_restart();
      int n;
      clearLogs();
      readyB = 1'b1;
      startB = 1'b1;
      tick();
      startB = 1'b0;
      for (int i = 0; i < 12; i++) begin
         validB = 1'b1;
         pixB = 8'(i);
         if (i == 5) startB = 1'b1;
         tick();
         validB = 1'b0;
         startB = 1'b0;
         if (i == 5) begin
            checks++;
            if (busyB !== 1'b1) begin
               errors++;
               $display("[TB] FAIL restartIgnored: busy=%b, need 1", busyB);
            end
         end
         tick();
      end
      for (int i = 12; i < 14; i++) begin
         validB = 1'b1;
         pixB = 8'(i);
         tick();
      end
      validB = 1'b0;
      n = 0;
      while (doneCntB == 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (doneCntB != 1 || logAddrB.size() != 12) begin
         errors++;
         $display("[TB] FAIL skip0Counts: done=%0d writes=%0d, need 1 12", doneCntB, logAddrB.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (logAddrB[i] !== 4'(expAddr[i]) || logDataB[i] !== 8'(i)) begin
               errors++;
               $display("[TB] FAIL skip0Write%0d: addr=%0d data=%h, need %0d %h", i, logAddrB[i], logDataB[i], expAddr[i], 8'(i));
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      clearLogs();
      readyA = 1'b1;
      pulseStartA();
      for (int i = 0; i < 7; i++) begin
         validA = 1'b1;
         pixA = 8'(i);
         readyA = (i == 6) ? 1'b0 : 1'b1;
         tick();
      end
      validA = 1'b0;
      readyA = 1'b1;
      checks++;
      if (logAddrA.size() != 3 || weA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL preResetState: writes=%0d we=%b, need 3 1", logAddrA.size(), weA);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({weA, addrA, dataA, busyA, doneA, ovfA} !== 16'h0) begin
         errors++;
         $display("[TB] FAIL midResetOutputs: got %h, need 0", {weA, addrA, dataA, busyA, doneA, ovfA});
      end
      tick();
      tick();
      tick();
      checks++;
      if (logAddrA.size() != 3) begin
         errors++;
         $display("[TB] FAIL noWriteAfterReset: writes=%0d, need 3", logAddrA.size());
      end
      rst = 1'b1;
      tick();
      test_basic_frame();
   endtask

   initial begin
      rst = 1'b0;
      startA = 1'b0; validA = 1'b0; readyA = 1'b1; pixA = '0;
      startB = 1'b0; validB = 1'b0; readyB = 1'b1; pixB = '0;
      clearLogs();
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_overflow();
      test_skip0_restart();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
